mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  Initiator side of the DataMemory port (DAddr/DataIn/DataOut, active-low RD/WR).
//  Accepts load/store requests from the CPU core and sequences them onto the memory bus.
//  Supports byte, half and word access; sub-word stores use read-modify-write.
//  Sits between the EX/MEM stage and DataMemory.
// PARAMETERS
//  ADDR_W      32  request/memory address width
//  BIG_ENDIAN  1   1: byte at addr+0 is DataIn[31:24]; 0: byte at addr+0 is DataIn[7:0]
// PORTS
//  CLK        in   1       clock; all state changes on the rising edge
//  Reset      in   1       asynchronous, active-low reset
//  req_valid  in   1       core request present
//  req_ready  out  1       controller can accept a request
//  req_we     in   1       1 = store, 0 = load
//  req_size   in   2       00 byte, 01 half, 10 word, 11 reserved
//  req_signed in   1       loads only: 1 = sign-extend, 0 = zero-extend
//  req_addr   in   ADDR_W  byte address
//  req_wdata  in   32      store data, right-justified
//  rsp_valid  out  1       response present
//  rsp_ready  in   1       core accepts the response
//  rsp_rdata  out  32      load result, extended per req_signed; 0 for stores
//  rsp_err    out  1       misaligned or reserved-size request (MISALIGN_TRAP_EN only)
//  DAddr      out  ADDR_W  memory address, always word-aligned ([1:0] = 0)
//  DataIn     out  32      memory write data
//  DataOut    in   32      memory read data, combinational from DAddr while RD = 0
//  RD         out  1       active-low read enable; 1 = memory output high-Z
//  WR         out  1       active-low write enable; memory writes on the CLK falling edge
// BEHAVIOUR
//  Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, DAddr=0, DataIn=0,
//   RD=1, WR=1, state=IDLE.
//  All outputs are decoded from registered state and registers, so they are glitch-free.
//  FSM states: IDLE, READ, WRITE, RESP.
//   IDLE:  req_ready=1. On req_valid, latch the request.
//          Go to WRITE for a word store, otherwise go to READ.
//   READ:  RD=0, DAddr=addr&~3. Capture DataOut at the rising edge ending the cycle.
//          Go to RESP for a load, WRITE for a sub-word store.
//   WRITE: WR=0, DataIn = merged word: captured word with the addressed lanes replaced.
//          Memory commits on the mid-cycle falling edge. Go to RESP.
//   RESP:  rsp_valid=1; rsp_rdata and rsp_err held stable. On rsp_ready, go to IDLE.
//  req_ready=0 in every state except IDLE. Requests presented then are ignored, not queued.
//  Latency, accept edge to rsp_valid: load 2 cycles; word store 2; sub-word store 3.
//   Minimum issue interval = latency + 1.
//  RD and WR are never low in the same cycle. Both return to 1 in IDLE and RESP.
//  Lane select: half uses addr[1], byte uses addr[1:0], ordered per BIG_ENDIAN.
//  Extension: byte and half results are sign- or zero-extended to 32 bits.
//  Reset mid-operation forces RD=WR=1 immediately (asynchronous).
//   A WRITE cut before the falling edge does not commit. State returns to IDLE.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//   A half with addr[0]=1, a word with addr[1:0]!=0, or size 11 goes IDLE->RESP.
//   RD and WR stay 1, rsp_err=1, rsp_rdata=0.
//  MISALIGN_TRAP_EN undefined: rsp_err is tied to 0.
//   Offending low address bits are ignored (half: addr[0]; word: addr[1:0]).
//   Size 11 is treated as word.
// STRUCTURE
//  Package mem_access_pkg:
//   SIZE_BYTE/SIZE_HALF/SIZE_WORD localparams, FSM state encoding, lane-mask function.
//  Sub-module mem_lane_align (combinational): load extract+extend and store merge,
//   parameterised by BIG_ENDIAN.
// TESTING
//  1 sw addr 8 data 0x00000008: WRITE cycle shows DAddr=8, WR=0, RD=1, DataIn=8;
//    rsp 2 cycles after accept. Then lw 8 -> RD=0, rsp_rdata=0x00000008.
//  2 With mem[12]=0x11223344: sb addr 13 data 0xA5 -> READ then WRITE, DataIn=0x11A53344.
//    lb 13 -> 0xFFFFFFA5. lbu 13 -> 0x000000A5.
//  3 sh addr 14 data 0xBEEF -> mem[12]=0x11A5BEEF.
//    lh signed 14 -> 0xFFFFBEEF. lhu 14 -> 0x0000BEEF.
//  4 lw addr 9: with MISALIGN_TRAP_EN -> rsp_err=1, RD and WR never low.
//    Without it -> DAddr=8, rsp_rdata=mem[8].
//  5 rsp_ready=0 for 3 cycles after a load: rsp_valid and rsp_rdata held, req_ready=0,
//    a competing req_valid is ignored. Completes on rsp_ready=1.
//  6 Reset low during the first half of WRITE (sw 12 data 0xDEADBEEF) -> WR=1 at once,
//    all outputs at reset values. Later lw 12 returns the prior 0x11A5BEEF.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: access-size codes, controller state encoding and byte-lane helpers
// shared by the DataMemory access controller and its lane aligner.
package mem_access_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } state_t;

    // Lowest byte lane (lane 0 = bits [7:0]) touched by an access.
    function automatic logic [1:0] lane_base(input logic [1:0] size,
                                             input logic [1:0] addr_lo,
                                             input logic       big_endian);
        logic [1:0] base;
        base = 2'd0;
        if (size == SIZE_BYTE)
            base = big_endian ? (2'd3 - addr_lo) : addr_lo;
        else if (size == SIZE_HALF)
            base = (addr_lo[1] ^ big_endian) ? 2'd2 : 2'd0;
        return base;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                             input logic [1:0] addr_lo,
                                             input logic       big_endian);
        logic [3:0] m;
        case (size)
            SIZE_BYTE: m = 4'b0001;
            SIZE_HALF: m = 4'b0011;
            default:   m = 4'b1111;
        endcase
        return m << lane_base(size, addr_lo, big_endian);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering; extracts and extends load data
// and merges right-justified store data into a memory word.
module mem_lane_align
    import mem_access_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        sign_ext,
    input  logic [31:0] mem_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [4:0]  shamt;
    logic [3:0]  mask;
    logic [31:0] byte_mask;
    logic [31:0] lanes;

    always_comb begin
        shamt = {lane_base(size, addr_lo, BIG_ENDIAN), 3'b000};
        mask  = lane_mask(size, addr_lo, BIG_ENDIAN);
        for (int i = 0; i < 4; i++)
            byte_mask[i*8 +: 8] = {8{mask[i]}};
        lanes = mem_word >> shamt;
        case (size)
            SIZE_BYTE: load_data = {{24{sign_ext & lanes[7]}}, lanes[7:0]};
            SIZE_HALF: load_data = {{16{sign_ext & lanes[15]}}, lanes[15:0]};
            default:   load_data = lanes;
        endcase
        // Unaddressed lanes keep the word captured during the read phase.
        store_word = (mem_word & ~byte_mask) | ((wdata << shamt) & byte_mask);
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences core load/store requests onto the DataMemory bus, using
// read-modify-write for sub-word stores. Optional define: MISALIGN_TRAP_EN.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] DAddr,
    output logic [31:0]       DataIn,
    input  logic [31:0]       DataOut,
    output logic              RD,
    output logic              WR
);

    state_t            state_q, state_d;
    logic              we_q, signed_q, err_q, rd_q, wr_q;
    logic [1:0]        size_q, addr_lo_q;
    logic [31:0]       wdata_q, datain_q, rdata_q;
    logic [ADDR_W-1:0] daddr_q;
    logic [1:0]        req_size_eff;
    logic              req_bad, accept, word_store;
    logic [31:0]       load_data, store_word;

`ifdef MISALIGN_TRAP_EN
    assign req_bad = (req_size == SIZE_RSVD) ||
                     ((req_size == SIZE_HALF) && req_addr[0]) ||
                     ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign req_bad = 1'b0;
`endif

    // Reserved size behaves as a word; low address bits are ignored by lane selection.
    assign req_size_eff = (req_size == SIZE_RSVD) ? SIZE_WORD : req_size;
    assign accept       = (state_q == IDLE) && req_valid;
    assign word_store   = req_we && (req_size_eff == SIZE_WORD);

    mem_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
        .size      (size_q),
        .addr_lo   (addr_lo_q),
        .sign_ext  (signed_q),
        .mem_word  (DataOut),
        .wdata     (wdata_q),
        .load_data (load_data),
        .store_word(store_word)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_bad)         state_d = RESP;
                    else if (word_store) state_d = WRITE;
                    else                 state_d = READ;
                end
            end
            READ:    state_d = we_q ? WRITE : RESP;
            WRITE:   state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // RD/WR are flopped from the next state so the bus strobes come straight off registers.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            signed_q  <= 1'b0;
            err_q     <= 1'b0;
            rd_q      <= 1'b1;
            wr_q      <= 1'b1;
            size_q    <= SIZE_BYTE;
            addr_lo_q <= 2'b00;
            wdata_q   <= '0;
            datain_q  <= '0;
            rdata_q   <= '0;
            daddr_q   <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= (state_d != READ);
            wr_q    <= (state_d != WRITE);
            if (accept) begin
                we_q      <= req_we;
                size_q    <= req_size_eff;
                signed_q  <= req_signed;
                addr_lo_q <= req_addr[1:0];
                wdata_q   <= req_wdata;
                err_q     <= req_bad;
                rdata_q   <= '0;
                if (!req_bad)  daddr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
                if (word_store) datain_q <= req_wdata;
            end
            if (state_q == READ) begin
                if (we_q) datain_q <= store_word;
                else      rdata_q  <= load_data;
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign DAddr     = daddr_q;
    assign DataIn    = datain_q;
    assign RD        = rd_q;
    assign WR        = wr_q;

endmodule
